// File: rtl/car_warning_ctrl.sv
// -----------------------------------------------------------------------------
// car_warning_ctrl
//
// Seat-belt / door warning controller. The three cabin switches are
// synchronised (2 flops) and debounced. While the ignition is on and the belt
// is unfastened, the FSM waits out a grace period, then pulses Alarm for a
// bounded number of chimes and mutes itself. A debounced door-ajar condition
// (ignition on, door open) holds Alarm high regardless of the FSM state.
//
// Ports:
//   Clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   DoorClose  raw switch, 1 = door closed (asynchronous)
//   Ignition   raw switch, 1 = ignition on (asynchronous)
//   SeatBelt   raw switch, 1 = belt fastened (asynchronous)
//   Alarm      alarm drive (registered)
//   DoorAjar   registered debounced Ignition & ~DoorClose
//   State      FSM state: 0 IDLE, 1 GRACE, 2 CHIME, 3 MUTE
//   ChimeCnt   completed chimes in the current episode
// -----------------------------------------------------------------------------
module car_warning_ctrl #(
  parameter int DB_CYC     = 4,
  parameter int GRACE_CYC  = 8,
  parameter int ON_CYC     = 3,
  parameter int OFF_CYC    = 3,
  parameter int MAX_CHIMES = 5,
  parameter int TW         = 8
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            DoorClose,
  input  logic                            Ignition,
  input  logic                            SeatBelt,
  output logic                            Alarm,
  output logic                            DoorAjar,
  output logic [1:0]                      State,
  output logic [$clog2(MAX_CHIMES+1)-1:0] ChimeCnt
);

  localparam int CW = $clog2(MAX_CHIMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRACE = 2'd1,
    CHIME = 2'd2,
    MUTE  = 2'd3
  } state_e;

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } phase_e;

  // Bit positions within the input vectors.
  localparam int I_DOOR = 0;
  localparam int I_IGN  = 1;
  localparam int I_BELT = 2;

  // Reset image of sync/debounce stages: door closed, ignition off, belt off.
  localparam logic [2:0] IN_RST = 3'b001;

  localparam logic [TW-1:0] DB_LAST    = TW'(DB_CYC - 1);
  localparam logic [TW-1:0] GRACE_LAST = TW'(GRACE_CYC - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYC - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYC - 1);
  localparam logic [CW-1:0] CHIME_MAX  = CW'(MAX_CHIMES);

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [TW-1:0] dbc_q [3];
  logic [TW-1:0] dbc_d [3];

  assign raw = {SeatBelt, Ignition, DoorClose};

  // NOTE: every variable gets a default before any branch, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      dbc_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // The flip and the counter clear happen on the same edge.
        if (dbc_q[i] == DB_LAST) deb_d[i] = ~deb_q[i];
        else                     dbc_d[i] = dbc_q[i] + TW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its sources regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= IN_RST;
      sync2_q <= IN_RST;
      deb_q   <= IN_RST;
      // NOTE: this small counter array is control state, not bulk storage, so
      // each entry is reset like an ordinary flop.
      for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Warning FSM
  // ---------------------------------------------------------------------------
  logic          warn;
  logic          ajar_d, ajar_q;
  logic          alarm_d, alarm_q;
  state_e        state_d, state_q;
  phase_e        phase_d, phase_q;
  logic [TW-1:0] timer_d, timer_q;
  logic [CW-1:0] cnt_d, cnt_q, cnt_inc;

  assign warn   = deb_q[I_IGN] & ~deb_q[I_BELT];
  assign ajar_d = deb_q[I_IGN] & ~deb_q[I_DOOR];

  // Saturating increment keeps ChimeCnt from ever wrapping.
  assign cnt_inc = (cnt_q == CHIME_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (warn) begin
          state_d = GRACE;
          timer_d = '0;
        end
      end

      GRACE: begin
        if (!warn) begin
          state_d = IDLE;
          timer_d = '0;
          cnt_d   = '0;
        end else if (timer_q == GRACE_LAST) begin
          state_d = CHIME;
          phase_d = PH_ON;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      CHIME: begin
        // Losing the warn condition outranks any phase expiry on this edge,
        // so a chime completing simultaneously is not counted.
        if (!warn) begin
          state_d = IDLE;
          phase_d = PH_OFF;
          timer_d = '0;
          cnt_d   = '0;
        end else if (phase_q == PH_ON) begin
          if (timer_q == ON_LAST) begin
            phase_d = PH_OFF;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          if (timer_q == OFF_LAST) begin
            timer_d = '0;
            cnt_d   = cnt_inc;
            if (cnt_inc == CHIME_MAX) begin
              state_d = MUTE;
              phase_d = PH_OFF;
            end else begin
              phase_d = PH_ON;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      MUTE: begin
        if (!warn) begin
          state_d = IDLE;
          timer_d = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = PH_OFF;
        timer_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Alarm is registered from next-state values, which gives the same timing
  // as decoding the state registers but with no logic after the flop.
  assign alarm_d = ((state_d == CHIME) && (phase_d == PH_ON)) | ajar_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_OFF;
      timer_q <= '0;
      cnt_q   <= '0;
      ajar_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ajar_q  <= ajar_d;
      alarm_q <= alarm_d;
    end
  end

  assign Alarm    = alarm_q;
  assign DoorAjar = ajar_q;
  assign State    = state_q;
  assign ChimeCnt = cnt_q;

endmodule

// File: tb/tb_car_warning_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_warning_ctrl
//
// Directed bench for car_warning_ctrl with default parameters. A table of
// {inputs, cycles to wait, expected outputs} rows drives the main scenario;
// hand-written sequences cover asynchronous reset and full chime episodes
// (one of them with filtered SeatBelt glitches).
//
// Timing reference: inputs change 1 time unit after a rising edge ("edge 0");
// the first synchroniser flop captures them on edge 1, the debounced value
// flips on edge 6 and registered FSM/door outputs react on edge 7.
// -----------------------------------------------------------------------------
module tb_car_warning_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_GRACE = 1;
  localparam int S_CHIME = 2;
  localparam int S_MUTE  = 3;

  logic       Clk;
  logic       Rst_n;
  logic       DoorClose;
  logic       Ignition;
  logic       SeatBelt;
  logic       Alarm;
  logic       DoorAjar;
  logic [1:0] State;
  logic [2:0] ChimeCnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic door;
    logic ign;
    logic belt;
    int   cycles;
    int   st;
    int   alarm;
    int   ajar;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  car_warning_ctrl #(
    .DB_CYC    (4),
    .GRACE_CYC (8),
    .ON_CYC    (3),
    .OFF_CYC   (3),
    .MAX_CHIMES(5),
    .TW        (8)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .DoorClose(DoorClose),
    .Ignition (Ignition),
    .SeatBelt (SeatBelt),
    .Alarm    (Alarm),
    .DoorAjar (DoorAjar),
    .State    (State),
    .ChimeCnt (ChimeCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic door, input logic ign, input logic belt,
                     input int cycles, input int st, input int alarm,
                     input int ajar, input int cnt);
    vec_t v;
    v.door = door; v.ign = ign; v.belt = belt; v.cycles = cycles;
    v.st = st; v.alarm = alarm; v.ajar = ajar; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check_all(input string tag, input int st, input int alarm,
                           input int ajar, input int cnt);
    check({tag, " State"},    int'(State),    st);
    check({tag, " Alarm"},    int'(Alarm),    alarm);
    check({tag, " DoorAjar"}, int'(DoorAjar), ajar);
    check({tag, " ChimeCnt"}, int'(ChimeCnt), cnt);
  endtask

  // Full warning episode starting from a raw W edge applied after edge 0, with
  // the door closed. Optionally injects 3-cycle SeatBelt pulses every 10
  // cycles once the belt has debounced low; they must change nothing.
  task automatic episode(input string tag, input bit glitch);
    int est, eal, ecnt;
    for (int e = 1; e <= 50; e++) begin
      step();
      if (e < 7) begin
        est = S_IDLE;  eal = 0; ecnt = 0;
      end else if (e < 15) begin
        est = S_GRACE; eal = 0; ecnt = 0;
      end else if (e < 45) begin
        est  = S_CHIME;
        eal  = (((e - 15) % 6) < 3) ? 1 : 0;
        ecnt = (e - 15) / 6;
      end else begin
        est = S_MUTE;  eal = 0; ecnt = 5;
      end
      check_all($sformatf("%s e%0d", tag, e), est, eal, 0, ecnt);
      if (glitch) SeatBelt = (e >= 10 && (e % 10) < 3) ? 1'b1 : 1'b0;
    end
    SeatBelt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n     = 1'b0;
    DoorClose = 1'b1;
    Ignition  = 1'b0;
    SeatBelt  = 1'b0;

    // ---- Stimulus table (door, ign, belt, cycles, State, Alarm, Ajar, Cnt)
    // First episode: Ignition rises.
    add(1, 1, 0,  6, S_IDLE,  0, 0, 0);  // edge 6: debounced, FSM not yet
    add(1, 1, 0,  1, S_GRACE, 0, 0, 0);  // edge 7
    add(1, 1, 0,  7, S_GRACE, 0, 0, 0);  // edge 14: last grace cycle
    add(1, 1, 0,  1, S_CHIME, 1, 0, 0);  // edge 15: first Alarm-high cycle
    add(1, 1, 0,  2, S_CHIME, 1, 0, 0);  // edge 17: third high cycle
    add(1, 1, 0,  1, S_CHIME, 0, 0, 0);  // edge 18: first low cycle
    add(1, 1, 0,  3, S_CHIME, 1, 0, 1);  // edge 21: chime 1 done
    add(1, 1, 0,  6, S_CHIME, 1, 0, 2);  // edge 27
    add(1, 1, 0, 17, S_CHIME, 0, 0, 4);  // edge 44: last low cycle
    add(1, 1, 0,  1, S_MUTE,  0, 0, 5);  // edge 45
    add(1, 1, 0, 10, S_MUTE,  0, 0, 5);  // stays muted
    // Door opened while muted.
    add(0, 1, 0,  6, S_MUTE,  0, 0, 5);
    add(0, 1, 0,  1, S_MUTE,  1, 1, 5);
    add(0, 1, 0, 10, S_MUTE,  1, 1, 5);
    // Door closed again.
    add(1, 1, 0,  6, S_MUTE,  1, 1, 5);
    add(1, 1, 0,  1, S_MUTE,  0, 0, 5);
    // Belt fastened: re-arm through IDLE.
    add(1, 1, 1,  6, S_MUTE,  0, 0, 5);
    add(1, 1, 1,  1, S_IDLE,  0, 0, 0);
    add(1, 1, 1,  5, S_IDLE,  0, 0, 0);
    // Belt released: second episode, aborted with ChimeCnt=2 on the edge
    // where the third chime would complete.
    add(1, 1, 0,  7, S_GRACE, 0, 0, 0);
    add(1, 1, 0,  8, S_CHIME, 1, 0, 0);  // r15
    add(1, 1, 0, 11, S_CHIME, 0, 0, 1);  // r26, belt rises after this
    add(1, 1, 1,  1, S_CHIME, 1, 0, 2);  // r27
    add(1, 1, 1,  5, S_CHIME, 0, 0, 2);  // r32: OFF timer at last cycle
    add(1, 1, 1,  1, S_IDLE,  0, 0, 0);  // r33: IDLE wins, no increment
    add(1, 1, 1,  3, S_IDLE,  0, 0, 0);
    // Grace abort: Ignition drops so the FSM sees ~W at GRACE timer=5.
    add(1, 1, 0,  6, S_IDLE,  0, 0, 0);
    add(1, 0, 0,  1, S_GRACE, 0, 0, 0);  // timer 0
    add(1, 0, 0,  5, S_GRACE, 0, 0, 0);  // timer 5
    add(1, 0, 0,  1, S_IDLE,  0, 0, 0);
    add(1, 0, 0, 10, S_IDLE,  0, 0, 0);
    // Ignition re-raised: a full 8-cycle grace again.
    add(1, 1, 0,  7, S_GRACE, 0, 0, 0);
    add(1, 1, 0,  7, S_GRACE, 0, 0, 0);
    add(1, 1, 0,  1, S_CHIME, 1, 0, 0);

    // ---- Reset state
    #1;
    check_all("reset", S_IDLE, 0, 0, 0);
    repeat (3) step();
    Rst_n = 1'b1;
    repeat (3) step();
    check_all("post-reset idle", S_IDLE, 0, 0, 0);

    // ---- Table-driven scenario
    foreach (tbl[i]) begin
      DoorClose = tbl[i].door;
      Ignition  = tbl[i].ign;
      SeatBelt  = tbl[i].belt;
      repeat (tbl[i].cycles) step();
      check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].alarm,
                tbl[i].ajar, tbl[i].cnt);
    end

    // ---- Asynchronous reset mid-CHIME with Alarm high: no clock edge needed
    #2;
    Rst_n = 1'b0;
    #1;
    check_all("async reset", S_IDLE, 0, 0, 0);
    step();
    check_all("held reset", S_IDLE, 0, 0, 0);
    Rst_n = 1'b1;
    // Inputs unchanged (ignition on, belt off): the whole sequence repeats.
    episode("after reset", 1'b0);

    // ---- Belt fastened to re-arm, then an episode with belt glitches
    SeatBelt = 1'b1;
    repeat (7) step();
    check_all("rearm", S_IDLE, 0, 0, 0);
    repeat (3) step();
    SeatBelt = 1'b0;
    episode("glitch", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
